// File: rtl/fetch_lsu.sv
`default_nettype none
// fetch_lsu: two-byte instruction fetcher and load/store arbiter in front of a 256x8 synchronous memory.
// Rev 1.0
module fetch_lsu #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   output logic       instr_valid,
   input  logic       instr_ready,
   output logic [7:0] instr_op,
   output logic [7:0] instr_arg,
   output logic [7:0] instr_pc,
   input  logic       redirect_en,
   input  logic [7:0] redirect_pc,
   input  logic       ls_req,
   input  logic       ls_we,
   input  logic [7:0] ls_addr,
   input  logic [7:0] ls_wdata,
   output logic [7:0] ls_rdata,
   output logic       ls_done,
   output logic [7:0] addr,
   output logic       memory_r_en,
   output logic       memory_w_en,
   output logic [7:0] mem_in,
   input  logic [7:0] mem_out
);

   typedef enum logic [2:0] {
      S_F_OP     = 3'd0,
      S_F_ARG    = 3'd1,
      S_F_CAP    = 3'd2,
      S_HOLD     = 3'd3,
      S_LS_RD    = 3'd4,
      S_LS_RWAIT = 3'd5,
      S_LS_WR    = 3'd6
   } state_t;

   state_t     r_state;
   logic [7:0] r_pc;
   logic [7:0] r_op;
   logic [7:0] r_arg;
   logic [7:0] r_ipc;
   logic       r_ret_hold;
   logic       r_valid;

   state_t     w_ls_state;
   logic [7:0] w_addr;
   logic       w_r_en;
   logic       w_w_en;
   logic [7:0] w_mem_in;
   logic       w_ls_done;
   logic [7:0] w_ls_rdata;

   assign w_ls_state = ls_we ? S_LS_WR : S_LS_RD;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_F_OP;
         r_pc       <= RESET_PC;
         r_op       <= 8'h00;
         r_arg      <= 8'h00;
         r_ipc      <= 8'h00;
         r_ret_hold <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_F_OP: begin
               // A redirect here restarts the fetch so the opcode read at the stale pc is discarded.
               if (ls_req) begin
                  r_state    <= w_ls_state;
                  r_ret_hold <= 1'b0;
               end else if (redirect_en) begin
                  r_state <= S_F_OP;
               end else begin
                  r_state <= S_F_ARG;
               end
            end
            S_F_ARG: begin
               r_op    <= mem_out;
               r_state <= redirect_en ? S_F_OP : S_F_CAP;
            end
            S_F_CAP: begin
               r_arg <= mem_out;
               r_ipc <= r_pc;
               if (redirect_en) begin
                  r_state <= S_F_OP;
               end else begin
                  r_state <= S_HOLD;
                  r_valid <= 1'b1;
               end
            end
            S_HOLD: begin
               if (redirect_en || instr_ready) begin
                  if (instr_ready) begin
                     r_pc <= r_pc + 8'd2;
                  end
                  r_ret_hold <= 1'b0;
                  r_state    <= ls_req ? w_ls_state : S_F_OP;
               end else if (ls_req) begin
                  r_ret_hold <= 1'b1;
                  r_state    <= w_ls_state;
               end else begin
                  r_valid <= 1'b1;
               end
            end
            S_LS_RD: begin
               r_state <= S_LS_RWAIT;
               if (redirect_en) begin
                  r_ret_hold <= 1'b0;
               end
            end
            S_LS_RWAIT, S_LS_WR: begin
               r_ret_hold <= 1'b0;
               if (r_ret_hold && !redirect_en) begin
                  r_state <= S_HOLD;
                  r_valid <= 1'b1;
               end else begin
                  r_state <= S_F_OP;
               end
            end
            default: begin
               r_state <= S_F_OP;
            end
         endcase
         // Redirect wins over the +2 of a same-cycle handshake.
         if (redirect_en) begin
            r_pc <= redirect_pc;
         end
      end
   end

   always_comb begin
      w_addr     = r_pc;
      w_r_en     = 1'b0;
      w_w_en     = 1'b0;
      w_mem_in   = 8'h00;
      w_ls_done  = 1'b0;
      w_ls_rdata = 8'h00;
      case (r_state)
         S_F_OP: begin
            w_r_en = 1'b1;
         end
         S_F_ARG: begin
            w_addr = r_pc + 8'd1;
            w_r_en = 1'b1;
         end
         S_LS_RD: begin
            w_addr = ls_addr;
            w_r_en = 1'b1;
         end
         S_LS_RWAIT: begin
            w_ls_done  = 1'b1;
            w_ls_rdata = mem_out;
         end
         S_LS_WR: begin
            w_addr    = ls_addr;
            w_w_en    = 1'b1;
            w_mem_in  = ls_wdata;
            w_ls_done = 1'b1;
         end
         default: begin
         end
      endcase
      // A store caught by reset is never issued and never reported.
      if (reset) begin
         w_r_en     = 1'b0;
         w_w_en     = 1'b0;
         w_ls_done  = 1'b0;
         w_ls_rdata = 8'h00;
      end
   end

   assign addr        = w_addr;
   assign memory_r_en = w_r_en;
   assign memory_w_en = w_w_en;
   assign mem_in      = w_mem_in;
   assign ls_done     = w_ls_done;
   assign ls_rdata    = w_ls_rdata;
   assign instr_valid = r_valid;
   assign instr_op    = r_op;
   assign instr_arg   = r_arg;
   assign instr_pc    = r_ipc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_lsu.sv
`default_nettype none
// tb_fetch_lsu: directed stimulus for fetch_lsu; expectations are queued and checked by an independent monitor.
module tb_fetch_lsu;

   logic       clk = 1'b0;
   logic       reset;
   logic       instr_valid, instr_ready;
   logic [7:0] instr_op, instr_arg, instr_pc;
   logic       redirect_en;
   logic [7:0] redirect_pc;
   logic       ls_req, ls_we;
   logic [7:0] ls_addr, ls_wdata, ls_rdata;
   logic       ls_done;
   logic [7:0] addr;
   logic       memory_r_en, memory_w_en;
   logic [7:0] mem_in;
   logic [7:0] mem_out = 8'h00;

   logic [7:0] mem [0:255];

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {logic [7:0] op; logic [7:0] arg; logic [7:0] pc;} instr_t;
   typedef struct packed {logic we; logic [7:0] a; logic [7:0] d;} ls_t;
   instr_t exp_i[$];
   ls_t    exp_ls[$];
   instr_t ei;
   ls_t    el;

   fetch_lsu #(.RESET_PC(8'h00)) dut (
      .clk(clk), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_arg(instr_arg), .instr_pc(instr_pc),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_rdata(ls_rdata), .ls_done(ls_done),
      .addr(addr), .memory_r_en(memory_r_en), .memory_w_en(memory_w_en),
      .mem_in(mem_in), .mem_out(mem_out)
   );

   always #5 clk = ~clk;

   // 256x8 synchronous memory: read data appears the cycle after the read is issued.
   always @(posedge clk) begin
      if (memory_w_en) mem[addr] <= mem_in;
      if (memory_r_en) mem_out <= mem[addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   always @(negedge clk) begin
      if (instr_valid && instr_ready) begin
         if (exp_i.size() == 0) begin
            fail_now("unexpected_instr");
         end else begin
            ei = exp_i.pop_front();
            check("instr_op_arg_pc", 32'({instr_op, instr_arg, instr_pc}), 32'(ei));
         end
      end
      if (ls_done) begin
         if (exp_ls.size() == 0) begin
            fail_now("unexpected_ls_done");
         end else begin
            el = exp_ls.pop_front();
            if (el.we) begin
               check("store_issue", 32'({memory_w_en, addr, mem_in}), 32'({1'b1, el.a, el.d}));
            end else begin
               check("load_rdata", 32'(ls_rdata), 32'(el.d));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!instr_valid && n < 40) begin
         tick();
         n++;
      end
      if (!instr_valid) fail_now(name);
   endtask

   task automatic accept(input string name);
      wait_valid(name);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
   endtask

   task automatic wait_addr(input logic [7:0] a, input string name);
      int n = 0;
      @(negedge clk);
      while (!(memory_r_en && addr == a) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!(memory_r_en && addr == a)) fail_now(name);
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      @(negedge clk);
      while (!ls_done && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cyc;
      logic ok_stable, ok_ren;

      reset = 1'b1; instr_ready = 1'b1; redirect_en = 1'b0; redirect_pc = 8'h00;
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = 8'h00; ls_wdata = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[0] = 8'h55; mem[1] = 8'h05; mem[2] = 8'hB5; mem[3] = 8'h06;
      mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
      mem[8'hFE] = 8'hE1; mem[8'hFF] = 8'hE2;

      // Reset state
      repeat (3) tick();
      @(negedge clk);
      check("reset_instr_outputs", 32'({instr_valid, instr_op, instr_arg, instr_pc}), 32'h0);
      check("reset_ls_mem_outputs", 32'({ls_done, ls_rdata, memory_r_en, memory_w_en}), 32'h0);

      // 1: first fetch latency and back-to-back interval
      exp_i.push_back({8'h55, 8'h05, 8'h00});
      tick();
      reset = 1'b0;
      cyc = 0;
      @(negedge clk);
      while (!instr_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("first_valid_latency", 32'(cyc), 32'd3);
      exp_i.push_back({8'hB5, 8'h06, 8'h02});
      tick();
      instr_ready = 1'b0;
      cyc = 0;
      while (!instr_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("second_instr_interval", 32'(cyc), 32'd4);

      // 2: backpressure holds outputs and issues no reads
      ok_stable = 1'b1;
      ok_ren    = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!instr_valid || {instr_op, instr_arg, instr_pc} !== 24'hB50602) ok_stable = 1'b0;
         if (memory_r_en) ok_ren = 1'b0;
      end
      check("hold_stable", 32'(ok_stable), 32'd1);
      check("hold_no_read", 32'(ok_ren), 32'd1);
      tick();
      accept("accept_pc02");

      // 3: redirect during F_ARG of the fetch at 0x04, then wrap from 0xFE
      wait_addr(8'h05, "farg_pc04");
      redirect_en = 1'b1;
      redirect_pc = 8'hFE;
      tick();
      redirect_en = 1'b0;
      @(negedge clk);
      check("abort_no_valid", 32'(instr_valid), 32'd0);
      check("redirect_fetch_addr", 32'({memory_r_en, addr}), 32'({1'b1, 8'hFE}));
      exp_i.push_back({8'hE1, 8'hE2, 8'hFE});
      tick();
      accept("accept_pcFE");
      exp_i.push_back({8'h55, 8'h05, 8'h00});
      accept("accept_wrap00");

      // 4: store then load while the instruction at 0x02 waits in HOLD
      exp_i.push_back({8'hB5, 8'h06, 8'h02});
      wait_valid("hold_pc02");
      exp_ls.push_back({1'b1, 8'h80, 8'hA5});
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h80; ls_wdata = 8'hA5;
      wait_done(cyc);
      check("store_latency", 32'(cyc), 32'd1);
      check("valid_low_during_ls", 32'(instr_valid), 32'd0);
      tick();
      ls_we = 1'b0;
      exp_ls.push_back({1'b0, 8'h80, 8'hA5});
      wait_done(cyc);
      check("load_latency", 32'(cyc), 32'd2);
      tick();
      ls_req = 1'b0;
      @(negedge clk);
      check("re_present_after_ls", 32'({instr_valid, instr_op, instr_arg, instr_pc}),
            32'({1'b1, 8'hB5, 8'h06, 8'h02}));
      tick();
      accept("accept_pc02_again");

      // 5: accept + redirect + load in the same HOLD cycle
      exp_i.push_back({8'h11, 8'h22, 8'h04});
      wait_valid("hold_pc04");
      exp_ls.push_back({1'b0, 8'h03, 8'h06});
      instr_ready = 1'b1; redirect_en = 1'b1; redirect_pc = 8'h10;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h03;
      tick();
      instr_ready = 1'b0;
      redirect_en = 1'b0;
      wait_done(cyc);
      check("combo_load_done", 32'(cyc), 32'd1);
      tick();
      ls_req = 1'b0;
      @(negedge clk);
      check("resume_at_redirect", 32'({memory_r_en, addr}), 32'({1'b1, 8'h10}));
      exp_i.push_back({8'h4A, 8'h4B, 8'h10});
      tick();
      accept("accept_pc10");

      // 6a: reset during LS_RD
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h20;
      tick();
      reset = 1'b1;
      @(negedge clk);
      check("reset_gates_lsrd", 32'({memory_r_en, memory_w_en, ls_done}), 32'h0);
      tick();
      reset = 1'b0;
      ls_req = 1'b0;
      @(negedge clk);
      check("reset_vals_after_ls", 32'({instr_valid, instr_op, instr_arg, instr_pc, ls_done}), 32'h0);
      check("restart_addr_after_ls", 32'({memory_r_en, addr}), 32'({1'b1, 8'h00}));
      exp_i.push_back({8'h55, 8'h05, 8'h00});
      tick();
      accept("accept_after_ls_reset");

      // 6b: reset during F_CAP of the fetch at 0x02
      wait_addr(8'h03, "farg_pc02");
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("reset_vals_after_fcap", 32'({instr_valid, instr_op, instr_arg, instr_pc}), 32'h0);
      check("restart_addr_after_fcap", 32'({memory_r_en, addr}), 32'({1'b1, 8'h00}));
      exp_i.push_back({8'h55, 8'h05, 8'h00});
      tick();
      accept("accept_after_fcap_reset");

      // 6c: reset during LS_WR drops the store
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h81; ls_wdata = 8'h77;
      tick();
      reset = 1'b1;
      @(negedge clk);
      check("reset_gates_lswr", 32'({memory_w_en, ls_done}), 32'h0);
      tick();
      reset = 1'b0;
      ls_req = 1'b0;
      repeat (3) tick();
      check("store_dropped", 32'(mem[8'h81]), 32'h0000_00DB);
      exp_i.push_back({8'h55, 8'h05, 8'h00});
      accept("accept_after_wr_reset");

      repeat (2) tick();
      check("instr_queue_drained", 32'(exp_i.size()), 32'd0);
      check("ls_queue_drained", 32'(exp_ls.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_lsu.md
Name: fetch_lsu

Overview:
- Sequencer directly upstream of the 256x8 single-port synchronous memory. It is the only block that drives the memory's addr, memory_r_en, memory_w_en and mem_in, and it consumes mem_out.
- Fetches two-byte instructions (opcode byte, then argument byte) for decode through a valid/ready handshake.
- Arbitrates single-byte data load/store requests from execute in the gaps between instruction fetches.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
instr_valid  out  1  instr_op/instr_arg/instr_pc hold a complete instruction
instr_ready  in  1  decode accepts the instruction
instr_op  out  8  opcode byte (memory[pc])
instr_arg  out  8  argument byte (memory[pc+1])
instr_pc  out  8  address of instr_op
redirect_en  in  1  branch/jump: load pc from redirect_pc
redirect_pc  in  8  new fetch address
ls_req  in  1  data access request; held until ls_done
ls_we  in  1  1 = store, 0 = load
ls_addr  in  8  data address
ls_wdata  in  8  store data
ls_rdata  out  8  load data; valid only while ls_done=1 and ls_we=0
ls_done  out  1  one-cycle completion pulse
addr  out  8  to memory addr
memory_r_en  out  1  to memory read enable
memory_w_en  out  1  to memory write enable
mem_in  out  8  to memory write data
mem_out  in  8  from memory; registered, valid the cycle after a read issue

Behaviour:
- Registers:
  - pc (8b), state, op/arg holding registers, ret_hold bit.
  - addr, memory_r_en, memory_w_en, mem_in, ls_done and ls_rdata are combinational from state, pc and ls_* inputs.
  - All memory enables are forced to 0 while reset=1.
- Reset values: pc=RESET_PC, state=F_OP, ret_hold=0, instr_valid=0, instr_op=instr_arg=instr_pc=0, ls_done=0, ls_rdata=0.
- Memory contract: a read issued in cycle N (r_en=1, addr=A) presents memory[A] on mem_out in cycle N+1. A write is issued in one cycle with w_en=1, addr and mem_in.
- States:
  - F_OP: addr=pc, r_en=1.
    - If ls_req=1: go to LS_RD or LS_WR instead (the read is wasted, harmless), ret_hold=0.
    - Otherwise go to F_ARG.
  - F_ARG: addr=pc+1 (mod 256), r_en=1; op<=mem_out. Go to F_CAP.
  - F_CAP: arg<=mem_out, instr_pc<=pc. Go to HOLD.
  - HOLD: instr_valid=1 and outputs stable.
    - On instr_valid&instr_ready: pc<=pc+2 (8-bit wrap, 0xFE->0x00); next is LS_* if ls_req=1 (ret_hold=0), else F_OP.
    - If not ready and ls_req=1: go to LS_* with ret_hold=1. instr_valid drops during the access and is reasserted, unchanged, on return.
  - LS_RD: addr=ls_addr, r_en=1. Go to LS_RWAIT.
  - LS_RWAIT: ls_done=1, ls_rdata=mem_out. Go to HOLD if ret_hold, else F_OP.
  - LS_WR: addr=ls_addr, w_en=1, mem_in=ls_wdata, ls_done=1. Return as for LS_RWAIT.
- Latency:
  - instr_valid rises 3 cycles after entering F_OP.
  - Minimum 4 cycles per instruction.
  - Load: ls_done 2 cycles after acceptance. Store: ls_done in the acceptance+1 cycle, i.e. the LS_WR cycle.
- ls_req is sampled only in F_OP and HOLD, so an instruction fetch is never torn. ls_req still high in the return state starts a new access.
- Redirect (highest priority):
  - In any state it sets pc<=redirect_pc. This overrides the +2 from a same-cycle handshake; instr_valid&instr_ready that cycle still counts as accepted.
  - In F_ARG/F_CAP/HOLD: the fetch is aborted and instr_valid is 0 the next cycle. Go to F_OP, or LS_* if ls_req=1 in HOLD.
  - In LS states: the access completes and ret_hold is cleared, so the block resumes at F_OP with the new pc.
- Reset asserted mid-operation: the next state is the reset state. Any pending store not yet issued is dropped and no ls_done is produced.

Test Plan:
1. Memory preloaded 0x55,0x05,0xB5,0x06 at 0..3, instr_ready=1 -> first instr_valid 4th cycle after reset release with op=0x55, arg=0x05, pc=0x00; next op=0xB5, arg=0x06, pc=0x02, 4 cycles later.
2. instr_ready=0 for 10 cycles -> instr_valid and outputs stable, memory_r_en=0 in HOLD; assert ready -> pc advances to 0x04.
3. redirect_en with redirect_pc=0xFE during F_ARG -> no valid for the aborted fetch; next instr_pc=0xFE, arg read from 0xFF, following fetch at 0x00 (wrap).
4. In HOLD (not ready) issue store ls_addr=0x80, ls_wdata=0xA5, then load 0x80 -> ls_done pulses, ls_rdata=0xA5; original instruction re-presented unchanged.
5. ls_req with instr_ready and redirect_en all high in HOLD -> instruction accepted, pc=redirect_pc, LS op served first, then fetch from redirect_pc.
6. reset pulsed during LS_RD and during F_CAP -> outputs return to reset values; fetch restarts at RESET_PC, no ls_done.
